// File: rtl/vis_readback_sched.sv
// vis_readback_sched: drains one completed visibilities bank from NBLK
// correlator blocks over a single-outstanding read bus and streams every
// returned word into the visibilities output buffer with a linear index.
//
// State table
//   state  | meaning
//   S_IDLE | waiting for start_i; bank latched and counters cleared on start
//   S_REQ  | one-cycle read strobe for {bank, slot, word} on block blk
//   S_WAIT | waiting for ack_i, bounded by TIMEOUT cycles
//   S_DONE | one-cycle completion pulse, coincident with the last vis_we_o
//
// Ports
//   clk_i, rst           bus clock, synchronous active-high reset
//   start_i, bank_i      drain request and bank to drain
//   clr_i                clears the sticky overrun_o / err_o flags
//   cyc_o .. adr_o       read bus master side (we_o tied low)
//   ack_i, dat_i         read bus response from the selected block
//   vis_we_o/adr_o/dat_o output-buffer write port
//   busy_o, done_o       drain status
//   overrun_o, err_o     sticky: start while busy, ack timeout
module vis_readback_sched #(
   parameter int ACCUM   = 32,
   parameter int NBLK    = 4,
   parameter int TRATE   = 12,
   parameter int TBITS   = 4,
   parameter int BBITS   = 3,
   parameter int ABITS   = 3 + TBITS + BBITS,
   parameter int CBITS   = 9,
   parameter int TIMEOUT = 15
) (
   input  logic             clk_i,
   input  logic             rst,
   input  logic             start_i,
   input  logic [BBITS-1:0] bank_i,
   input  logic             clr_i,
   output logic             cyc_o,
   output logic             stb_o,
   output logic             we_o,
   output logic             bst_o,
   output logic [NBLK-1:0]  sel_o,
   output logic [ABITS-1:0] adr_o,
   input  logic             ack_i,
   input  logic [ACCUM-1:0] dat_i,
   output logic             vis_we_o,
   output logic [CBITS-1:0] vis_adr_o,
   output logic [ACCUM-1:0] vis_dat_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             overrun_o,
   output logic             err_o
);

   localparam int NB = (NBLK > 1) ? $clog2(NBLK) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
   state_t state, state_nxt;

   logic [BBITS-1:0] bank;
   logic [2:0]       word;
   logic [TBITS-1:0] slot;
   logic [NB-1:0]    blk;
   logic [CBITS-1:0] idx;
   logic [TW-1:0]    tcnt;
   logic             last_word;
   logic             tmo;

   assign last_word = (word == 3'd7) && (slot == TBITS'(TRATE - 1)) && (blk == NB'(NBLK - 1));
   assign tmo       = (state == S_WAIT) && !ack_i && (tcnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk_i) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cyc_o     = 1'b0;
      stb_o     = 1'b0;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_i) state_nxt = S_REQ;
         end
         S_REQ: begin
            cyc_o     = 1'b1;
            stb_o     = 1'b1;
            busy_o    = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            cyc_o  = 1'b1;
            busy_o = 1'b1;
            if (ack_i)    state_nxt = last_word ? S_DONE : S_REQ;
            else if (tmo) state_nxt = S_IDLE;
         end
         S_DONE: begin
            cyc_o     = 1'b1;
            busy_o    = 1'b1;
            done_o    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Bus address/select are quiet outside a cycle so reset and idle show zeros.
   assign we_o  = 1'b0;
   assign bst_o = cyc_o && (word != 3'd7);
   assign sel_o = cyc_o ? (NBLK'(1) << blk) : '0;
   assign adr_o = cyc_o ? {bank, slot, word} : '0;

   always_ff @(posedge clk_i) begin
      if (rst) begin
         bank      <= '0;
         word      <= '0;
         slot      <= '0;
         blk       <= '0;
         idx       <= '0;
         tcnt      <= '0;
         vis_we_o  <= 1'b0;
         vis_adr_o <= '0;
         vis_dat_o <= '0;
         overrun_o <= 1'b0;
         err_o     <= 1'b0;
      end else begin
         vis_we_o <= 1'b0;

         if (state == S_IDLE && start_i) begin
            bank <= bank_i;
            word <= '0;
            slot <= '0;
            blk  <= '0;
            idx  <= '0;
         end

         if (state == S_REQ) tcnt <= '0;

         if (state == S_WAIT) begin
            if (ack_i) begin
               vis_dat_o <= dat_i;
               vis_adr_o <= idx;
               vis_we_o  <= 1'b1;
               idx       <= idx + 1'b1;
               if (word == 3'd7) begin
                  word <= '0;
                  if (slot == TBITS'(TRATE - 1)) begin
                     slot <= '0;
                     blk  <= (blk == NB'(NBLK - 1)) ? '0 : blk + 1'b1;
                  end else begin
                     slot <= slot + 1'b1;
                  end
               end else begin
                  word <= word + 1'b1;
               end
            end else begin
               tcnt <= tcnt + 1'b1;
            end
         end

         // Clear has priority over any new sticky event in the same cycle.
         if (clr_i) begin
            overrun_o <= 1'b0;
            err_o     <= 1'b0;
         end else begin
            if (start_i && state != S_IDLE) overrun_o <= 1'b1;
            if (tmo)                        err_o     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vis_readback_sched.sv
// Testbench for vis_readback_sched: a randomized-latency read slave, a
// write/read monitor and a reference model computing the expected index,
// address, select and data of every word of a drain from plain arithmetic.
module tb_vis_readback_sched;
   localparam int ACCUM   = 32;
   localparam int NBLK    = 4;
   localparam int TRATE   = 12;
   localparam int TBITS   = 4;
   localparam int BBITS   = 3;
   localparam int ABITS   = 10;
   localparam int CBITS   = 9;
   localparam int TIMEOUT = 15;
   localparam int NWORDS  = NBLK * TRATE * 8;

   logic             clk_i = 1'b0;
   logic             rst;
   logic             start_i;
   logic [BBITS-1:0] bank_i;
   logic             clr_i;
   logic             cyc_o, stb_o, we_o, bst_o;
   logic [NBLK-1:0]  sel_o;
   logic [ABITS-1:0] adr_o;
   logic             ack_i;
   logic [ACCUM-1:0] dat_i;
   logic             vis_we_o;
   logic [CBITS-1:0] vis_adr_o;
   logic [ACCUM-1:0] vis_dat_o;
   logic             busy_o, done_o, overrun_o, err_o;

   vis_readback_sched #(
      .ACCUM(ACCUM), .NBLK(NBLK), .TRATE(TRATE), .TBITS(TBITS), .BBITS(BBITS),
      .ABITS(ABITS), .CBITS(CBITS), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_i(clk_i), .rst(rst), .start_i(start_i), .bank_i(bank_i), .clr_i(clr_i),
      .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .bst_o(bst_o), .sel_o(sel_o),
      .adr_o(adr_o), .ack_i(ack_i), .dat_i(dat_i), .vis_we_o(vis_we_o),
      .vis_adr_o(vis_adr_o), .vis_dat_o(vis_dat_o), .busy_o(busy_o), .done_o(done_o),
      .overrun_o(overrun_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // slave control, written only by the main sequence
   int          epoch    = 0;
   int          fixed_lat = 2;
   int          drop_n   = -1;
   logic [31:0] salt     = 32'h0;

   // ---------------- reference model ----------------
   function automatic logic [ABITS-1:0] m_adr(int b, int i);
      return {3'(b), 4'((i / 8) % TRATE), 3'(i % 8)};
   endfunction

   function automatic logic [NBLK-1:0] m_sel(int i);
      return 4'(1 << (i / (TRATE * 8)));
   endfunction

   function automatic logic [ACCUM-1:0] m_dat(int b, int i, logic [31:0] s);
      return {s[17:0], m_sel(i), m_adr(b, i)};
   endfunction

   // ---------------- read slave ----------------
   int               s_epoch = 0;
   int               s_nreads = 0;
   int               s_cnt = 0;
   bit               s_pend = 1'b0;
   logic [ACCUM-1:0] s_dat;

   initial begin
      ack_i = 1'b0;
      dat_i = '0;
      forever begin
         @(posedge clk_i);
         #1;
         ack_i = 1'b0;
         if (epoch != s_epoch) begin
            s_epoch  = epoch;
            s_nreads = 0;
            s_pend   = 1'b0;
         end
         if (s_pend) begin
            s_cnt--;
            if (s_cnt == 0) begin
               ack_i  = 1'b1;
               dat_i  = s_dat;
               s_pend = 1'b0;
            end
         end
         if (stb_o && !s_pend) begin
            if (s_nreads != drop_n) begin
               s_pend = 1'b1;
               s_cnt  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
               s_dat  = {salt[17:0], sel_o, adr_o};
            end
            s_nreads++;
         end
      end
   end

   // ---------------- monitor ----------------
   logic [CBITS+ACCUM-1:0] wq[$];
   logic [NBLK+ABITS-1:0]  rq[$];
   int                     ndone = 0;
   logic [CBITS-1:0]       done_adr = '0;
   logic                   done_we = 1'b0;

   initial begin
      forever begin
         @(negedge clk_i);
         if (vis_we_o) wq.push_back({vis_adr_o, vis_dat_o});
         if (stb_o)    rq.push_back({sel_o, adr_o});
         if (done_o) begin
            ndone++;
            done_adr = vis_adr_o;
            done_we  = vis_we_o;
         end
      end
   end

   // ---------------- helpers ----------------
   int snap_w, snap_r, snap_d;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(string tag);
      chk({tag, "_cyc"}, 64'(cyc_o), 0);
      chk({tag, "_stb"}, 64'(stb_o), 0);
      chk({tag, "_we"}, 64'(we_o), 0);
      chk({tag, "_bst"}, 64'(bst_o), 0);
      chk({tag, "_sel"}, 64'(sel_o), 0);
      chk({tag, "_adr"}, 64'(adr_o), 0);
      chk({tag, "_vis_we"}, 64'(vis_we_o), 0);
      chk({tag, "_vis_adr"}, 64'(vis_adr_o), 0);
      chk({tag, "_vis_dat"}, 64'(vis_dat_o), 0);
      chk({tag, "_busy"}, 64'(busy_o), 0);
      chk({tag, "_done"}, 64'(done_o), 0);
      chk({tag, "_overrun"}, 64'(overrun_o), 0);
      chk({tag, "_err"}, 64'(err_o), 0);
   endtask

   task automatic do_start(int b);
      epoch++;
      bank_i  = 3'(b);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   // Returns in the DONE cycle after its falling edge, with queue snapshots.
   task automatic wait_done(string tag);
      int n = 0;
      while (!done_o && n < 5000) begin
         tick();
         n++;
      end
      chk({tag, "_done_seen"}, 64'(done_o), 1);
      @(negedge clk_i);
      #1;
      snap_w = wq.size();
      snap_r = rq.size();
      snap_d = ndone;
   endtask

   task automatic check_drain(string tag, int b, logic [31:0] s, int wb, int rb, int nd0);
      int nw, nr, n;
      logic [CBITS+ACCUM-1:0] w;
      logic [NBLK+ABITS-1:0]  r;
      nw = snap_w - wb;
      nr = snap_r - rb;
      chk({tag, "_nwrites"}, 64'(nw), 64'(NWORDS));
      chk({tag, "_nreads"}, 64'(nr), 64'(NWORDS));
      chk({tag, "_ndone"}, 64'(snap_d - nd0), 1);
      chk({tag, "_done_idx"}, 64'(done_adr), 64'(NWORDS - 1));
      chk({tag, "_done_with_we"}, 64'(done_we), 1);
      n = (nw < nr) ? nw : nr;
      if (n > NWORDS) n = NWORDS;
      for (int i = 0; i < n; i++) begin
         w = wq[wb + i];
         r = rq[rb + i];
         chk({tag, "_vis_adr"}, 64'(w[CBITS+ACCUM-1:ACCUM]), 64'(i));
         chk({tag, "_vis_dat"}, 64'(w[ACCUM-1:0]), 64'(m_dat(b, i, s)));
         chk({tag, "_rd_sel_adr"}, 64'(r), 64'({m_sel(i), m_adr(b, i)}));
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int b, b2, wb, rb, nd0, n, wcnt, wsz;
      logic [31:0] s;

      rst = 1'b1; start_i = 1'b0; bank_i = '0; clr_i = 1'b0;
      repeat (3) tick();
      check_zero("reset");
      rst = 1'b0;
      tick();

      // full drain of bank 2, fixed 2-cycle ack
      fixed_lat = 2;
      s = $urandom; salt = s;
      wb = wq.size(); rb = rq.size(); nd0 = ndone;
      do_start(2);
      chk("start_busy", 64'(busy_o), 1);
      chk("start_cyc", 64'(cyc_o), 1);
      chk("start_stb", 64'(stb_o), 1);
      chk("start_adr", 64'(adr_o), 64'(10'b010_0000_000));
      chk("start_sel", 64'(sel_o), 1);
      chk("start_bst", 64'(bst_o), 1);
      wait_done("d2");
      tick();
      check_drain("d2", 2, s, wb, rb, nd0);
      chk("d2_idle_busy", 64'(busy_o), 0);
      chk("d2_idle_cyc", 64'(cyc_o), 0);

      // random bank, random latency, overrun at word 50
      fixed_lat = 0;
      b = int'($urandom_range(0, 7));
      s = $urandom; salt = s;
      wb = wq.size(); rb = rq.size(); nd0 = ndone;
      do_start(b);
      n = 0;
      while (wq.size() - wb < 50 && n < 2000) begin tick(); n++; end
      chk("ovr_reach50", 64'(wq.size() - wb >= 50), 1);
      bank_i = 3'(b + 1); start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("ovr_set", 64'(overrun_o), 1);
      chk("ovr_busy", 64'(busy_o), 1);
      wait_done("ovr");
      tick();
      check_drain("ovr", b, s, wb, rb, nd0);
      chk("ovr_sticky", 64'(overrun_o), 1);

      // clear and start together in IDLE: clear wins, start accepted
      b2 = int'($urandom_range(0, 7));
      s = $urandom; salt = s;
      wb = wq.size(); rb = rq.size(); nd0 = ndone;
      epoch++;
      clr_i = 1'b1; start_i = 1'b1; bank_i = 3'(b2);
      tick();
      clr_i = 1'b0; start_i = 1'b0;
      chk("clr_start_ovr", 64'(overrun_o), 0);
      chk("clr_start_busy", 64'(busy_o), 1);
      chk("clr_start_bank", 64'(adr_o[ABITS-1:ABITS-3]), 64'(b2));
      wait_done("clrst");
      tick();
      check_drain("clrst", b2, s, wb, rb, nd0);

      // ack timeout on the read at index 10
      drop_n = 10;
      wb = wq.size(); nd0 = ndone;
      do_start(int'($urandom_range(0, 7)));
      n = 0; wcnt = 0;
      while (cyc_o && n < 1000) begin
         tick(); n++;
         if (stb_o) wcnt = 0;
         else if (cyc_o) wcnt++;
      end
      chk("tmo_cyc", 64'(cyc_o), 0);
      chk("tmo_wait_cycles", 64'(wcnt), 64'(TIMEOUT));
      chk("tmo_err", 64'(err_o), 1);
      chk("tmo_busy", 64'(busy_o), 0);
      chk("tmo_no_done", 64'(ndone - nd0), 0);
      chk("tmo_nwrites", 64'(wq.size() - wb), 10);
      tick();
      chk("tmo_no_done_late", 64'(ndone - nd0), 0);

      // restart after timeout drains from index 0
      drop_n = -1;
      b = int'($urandom_range(0, 7));
      s = $urandom; salt = s;
      wb = wq.size(); rb = rq.size(); nd0 = ndone;
      do_start(b);
      chk("restart_err_sticky", 64'(err_o), 1);
      wait_done("restart");
      tick();
      check_drain("restart", b, s, wb, rb, nd0);

      // back-to-back start of bank 7 in the first IDLE cycle after done_o
      fixed_lat = 0;
      s = $urandom; salt = s;
      clr_i = 1'b1; tick(); clr_i = 1'b0;
      chk("clr_err", 64'(err_o), 0);
      wb = wq.size(); rb = rq.size(); nd0 = ndone;
      do_start(5);
      wait_done("pre7");
      check_drain("pre7", 5, s, wb, rb, nd0);
      tick();
      s = $urandom; salt = s;
      wb = wq.size(); rb = rq.size(); nd0 = ndone;
      do_start(7);
      chk("b2b_busy", 64'(busy_o), 1);
      chk("b2b_no_overrun", 64'(overrun_o), 0);
      wait_done("b7");
      tick();
      check_drain("b7", 7, s, wb, rb, nd0);

      // reset while waiting at index 100, late ack afterwards
      fixed_lat = 4;
      s = $urandom; salt = s;
      wb = wq.size();
      do_start(int'($urandom_range(0, 7)));
      n = 0;
      while (!(wq.size() - wb >= 100 && cyc_o && !stb_o) && n < 3000) begin tick(); n++; end
      chk("rst_reach100", 64'(wq.size() - wb), 100);
      rst = 1'b1;
      tick();
      check_zero("rst_mid");
      rst = 1'b0;
      wsz = wq.size();
      repeat (10) tick();
      chk("rst_late_ack_no_write", 64'(wq.size() - wsz), 0);
      chk("rst_late_busy", 64'(busy_o), 0);
      chk("rst_late_cyc", 64'(cyc_o), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
